// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency, full-throughput word memory that answers cache fill reads.
// Define MEM_WR_FORWARD_EN to let writes update matching reads already in flight.
module mem_fill_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data_in,
  output logic [15:0]       o_data_out,
  output logic              o_data_valid
);
  localparam int DEPTH = 1 << (ADDR_W - 1);
  logic [15:0]       r_mem [0:DEPTH-1];
  logic              r_v   [0:LATENCY-1];
  logic [15:0]       r_d   [0:LATENCY-1];
`ifdef MEM_WR_FORWARD_EN
  logic [ADDR_W-2:0] r_idx [0:LATENCY-1];
`endif
  logic              r_out_v;
  logic [15:0]       r_out_d;
  logic [15:0]       w_nd  [0:LATENCY-1];
  logic [ADDR_W-2:0] w_idx;
  logic              w_we;
  logic              w_re;
  logic              w_unused;
  assign w_idx    = i_addr[ADDR_W-1:1];
  assign w_we     = i_enable & i_wr;
  assign w_re     = i_enable & ~i_wr;
  assign w_unused = i_addr[0];
  // Storage is never cleared; reset only blocks writes while asserted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
    end else if (w_we) begin
      r_mem[w_idx] <= i_data_in;
    end
  end
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
`ifdef MEM_WR_FORWARD_EN
      w_nd[i] = (w_we && r_v[i] && r_idx[i] == w_idx) ? i_data_in : r_d[i];
`else
      w_nd[i] = r_d[i];
`endif
    end
  end
  // Stage 0 takes the read at its acceptance edge; the output register adds the final cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_v[i] <= 1'b0;
        r_d[i] <= '0;
`ifdef MEM_WR_FORWARD_EN
        r_idx[i] <= '0;
`endif
      end
      r_out_v <= 1'b0;
      r_out_d <= '0;
    end else begin
      r_v[0] <= w_re;
      r_d[0] <= r_mem[w_idx];
`ifdef MEM_WR_FORWARD_EN
      r_idx[0] <= w_idx;
`endif
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= w_nd[i-1];
`ifdef MEM_WR_FORWARD_EN
        r_idx[i] <= r_idx[i-1];
`endif
      end
      r_out_v <= r_v[LATENCY-1];
      r_out_d <= w_nd[LATENCY-1];
    end
  end
  assign o_data_valid = r_out_v;
  assign o_data_out   = r_out_v ? r_out_d : 16'h0000;
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed bench for the fill responder at LATENCY=4 and LATENCY=1.
module tb_mem_fill_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, wr, en1, wr1;
  logic [15:0] addr, din, dout, addr1, din1, dout1;
  logic        dv, dv1;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_fill_responder u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_wr(wr), .i_addr(addr),
    .i_data_in(din), .o_data_out(dout), .o_data_valid(dv)
  );

  mem_fill_responder #(.LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .i_wr(wr1), .i_addr(addr1),
    .i_data_in(din1), .o_data_out(dout1), .o_data_valid(dv1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    en = e; wr = w; addr = a; din = d;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    en1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (dv !== 1'b0 || dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h, want valid=0 data=0000", dv, dout);
    end
    checks++;
    if (dv1 !== 1'b0 || dout1 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state_lat1: valid=%b data=%h, want valid=0 data=0000", dv1, dout1);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic ev;
    logic [15:0] ed;
    drive(1'b1, 1'b1, 16'h0010, 16'hA5A5);
    tick();
    for (int c = 0; c <= 6; c++) begin
      drive(c == 0, 1'b0, 16'h0010, 16'h0);
      tick();
      ev = (c == 4);
      ed = ev ? 16'hA5A5 : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL write_read c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    logic [15:0] ed;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'h0120 + 16'(2 * i), 16'h1000 + 16'(i));
      tick();
    end
    for (int c = 0; c <= 13; c++) begin
      drive(c < 8, 1'b0, 16'h0120 + 16'(2 * c), 16'h0);
      tick();
      ev = (c >= 4 && c < 12);
      ed = ev ? 16'h1000 + 16'(c - 4) : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL back_to_back c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
  endtask

  task automatic test_forward();
    logic ev;
    logic [15:0] ed;
    logic [15:0] fwd_val;
`ifdef MEM_WR_FORWARD_EN
    fwd_val = 16'h2222;
`else
    fwd_val = 16'h1111;
`endif
    drive(1'b1, 1'b1, 16'h0040, 16'h1111);
    tick();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 16'h0040, 16'h0);
      else if (c == 1) drive(1'b1, 1'b1, 16'h0040, 16'h2222);
      else drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      ev = (c == 4);
      ed = ev ? fwd_val : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL forward c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
    for (int c = 0; c <= 4; c++) begin
      drive(c == 0, 1'b0, 16'h0040, 16'h0);
      tick();
      ev = (c == 4);
      ed = ev ? 16'h2222 : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL forward_reread c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
  endtask

  task automatic test_addr_lsb();
    logic ev;
    logic [15:0] ed;
    drive(1'b1, 1'b1, 16'h0040, 16'h5A5A);
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'h7777);
    tick();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 16'h0041, 16'h0);
      else if (c == 1) drive(1'b1, 1'b0, 16'hFFFE, 16'h0);
      else drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      ev = (c == 4 || c == 5);
      ed = (c == 4) ? 16'h5A5A : (c == 5) ? 16'h7777 : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL addr_lsb c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic ev;
    logic [15:0] ed;
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) tick();
    checks++;
    if (dv !== 1'b1 || dout !== 16'hA5A5) begin
      failures++;
      $display("FAIL pre_async_reset: valid=%b data=%h, want valid=1 data=a5a5", dv, dout);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dv !== 1'b0 || dout !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: valid=%b data=%h, want valid=0 data=0000", dv, dout);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, (c == 0) ? 16'h0010 : (c == 1) ? 16'h0120 : 16'h0040, 16'h0);
      tick();
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dv !== 1'b0 || dout !== 16'h0000) begin
        failures++;
        $display("FAIL flush c=%0d: valid=%b data=%h, want valid=0 data=0000", c, dv, dout);
      end
    end
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, 1'b0, 16'h0010, 16'h0);
      tick();
      ev = (c == 4);
      ed = ev ? 16'hA5A5 : 16'h0000;
      checks++;
      if (dv !== ev || dout !== ed) begin
        failures++;
        $display("FAIL retained c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv, dout, ev, ed);
      end
    end
  endtask

  task automatic test_latency1();
    logic ev;
    logic [15:0] ed;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0008; din1 = 16'hBEEF;
    tick();
    addr1 = 16'h000A; din1 = 16'hCAFE;
    tick();
    for (int c = 0; c <= 3; c++) begin
      en1 = (c < 2); wr1 = 1'b0; din1 = 16'h0;
      addr1 = (c == 0) ? 16'h0008 : 16'h000A;
      tick();
      ev = (c == 1 || c == 2);
      ed = (c == 1) ? 16'hBEEF : (c == 2) ? 16'hCAFE : 16'h0000;
      checks++;
      if (dv1 !== ev || dout1 !== ed) begin
        failures++;
        $display("FAIL latency1 c=%0d: valid=%b data=%h, want valid=%b data=%h", c, dv1, dout1, ev, ed);
      end
    end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_forward();
    test_addr_lsb();
    test_reset_flush();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
